dpram_lsu: RTL and testbench
============================

# dpram_lsu

Load/store adapter that sits directly upstream of port B of the core's data dual-port RAM. It accepts byte/half/word load and store requests from the execute stage over a valid/ready handshake and drives the RAM's word address, byte write strobes and write data. It returns aligned, sign- or zero-extended load data one cycle later over a valid/ready response channel. Misaligned, out-of-range and illegal-size requests are rejected with an error response and never reach the RAM.

## Interface
Parameters:
- RAM_DEPTH, 2048, words in the attached RAM; must be a power of two.
- AW, clogb2(RAM_DEPTH-1), RAM word-address width; derived, not overridden.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.

Request channel:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads when high.
- req_wdata  in  32  store data, right-justified.

Response channel:
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  extended load data.
- rsp_err  out  1  request was rejected.

RAM port B:
- ram_addr  out  AW  word address.
- ram_en  out  1  port enable.
- ram_we  out  1  write enable.
- ram_wem  out  4  byte write strobes.
- ram_din  out  32  write data, lane-replicated.
- ram_dout  in  32  read data; the RAM has 1-cycle latency and holds its output while ram_en is low.

## Operation
- Accept: fire = req_valid & req_ready, with req_ready = !rsp_valid | rsp_ready. The block sustains one request per cycle.
- Error check (combinational on the request):
  - req_size == 11.
  - half with addr[0] != 0.
  - word with addr[1:0] != 0.
  - addr[31:2] >= RAM_DEPTH.
- RAM drive:
  - ram_en = fire & !err.
  - ram_addr = req_addr[AW+1:2].
  - ram_we = ram_en & req_we.
- Byte strobes: shifted left by addr[1:0].
  - byte: 0001.
  - half: 0011.
  - word: 1111.
- Write data (ram_din):
  - byte: wdata[7:0] replicated ×4.
  - half: wdata[15:0] replicated ×2.
  - word: wdata unchanged.
- Response registers, loaded on fire: pending, err, is_load, size, offset = addr[1:0], unsigned.
- Load data: the lane is selected from ram_dout by offset (byte: offset×8; half: offset[1]×16). It is then sign- or zero-extended per unsigned.
- Stores return rsp_rdata = 0 and rsp_err = 0. Errors return rsp_rdata = 0 and rsp_err = 1.
- Two-state control:
  - IDLE (rsp_valid = 0) → RESP on fire.
  - RESP → RESP on fire with rsp_ready.
  - RESP → IDLE on rsp_ready without fire.
  - RESP holds while rsp_ready = 0.

## Timing
- Reset values: rsp_valid = 0, rsp_err = 0, rsp_rdata = 0. All registered fields reset to 0. req_ready = 1 after reset.
- Latency: fire in cycle N → rsp_valid in cycle N+1, for loads, stores and errors alike.
- Stall: while rsp_valid & !rsp_ready:
  - req_ready = 0 and ram_en = 0.
  - ram_dout is held by the RAM, so rsp_rdata stays stable; the block stores no copy of it.
- Back-to-back: a load at N+1 following a store at N to the same word returns the stored data. Port B writes complete at the end of N.
- Error requests do not assert ram_en, but still occupy one response slot.
- Reset mid-operation: a pending response is discarded and rsp_valid drops asynchronously. A RAM write asserted in the reset cycle may or may not land.
- All RAM-side outputs are combinational from the request and state. There is no register between req_* and ram_*.

## Structure
- Size encodings (SZ_B, SZ_H, SZ_W) and the illegal code go in defines.v, shared with the decoder.
- Sub-module dpram_lsu_ld_align: a purely combinational lane select and extend, taking ram_dout, offset, size and unsigned, and producing 32-bit data. It is reused by the instruction-side alignment checks.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10.
  - Store cycle: ram_wem = 1111.
  - Load: rsp_rdata = 0xDEADBEEF at N+1, rsp_err = 0.
- Byte store 0x80 to 0x13.
  - Store cycle: ram_wem = 1000, ram_din = 0x80808080.
  - Signed byte load of 0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- Half load with addr = 0x11 → rsp_err = 1, rsp_rdata = 0, and ram_en never asserted.
  - The same with size = 11, and with word addr = RAM_DEPTH×4.
- Load with rsp_ready held low 5 cycles.
  - req_ready = 0 and rsp_rdata stable for all 5 cycles.
  - The next request is accepted in the cycle rsp_ready rises.
- Stream of 8 alternating stores and loads with rsp_ready = 1.
  - One fire per cycle, responses in order, each load sees the preceding store.
- rst_n pulsed low while rsp_valid = 1 → rsp_valid = 0 immediately, req_ready = 1 after release.

Source files
------------

// File: rtl/dpram_lsu_pkg.sv
// Shared types and helpers for the port-B load/store adapter.
// Size encodings are also used by the instruction-side alignment checks.
package dpram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Number of bits needed to represent value.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_lsu_if.sv
// Request, response and RAM port-B signals of the load/store adapter.
// The master side drives requests, accepts responses and models the RAM.
interface dpram_lsu_if #(parameter int AW = 11);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_wem;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output ram_addr, ram_en, ram_we, ram_wem, ram_din,
        input  ram_dout
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  ram_addr, ram_en, ram_we, ram_wem, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/dpram_lsu_ld_align.sv
// Combinational lane select and sign/zero extension of a 32-bit RAM word.
module dpram_lsu_ld_align
    import dpram_lsu_pkg::*;
(
    input  logic [31:0] dout_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = dout_i[{offset_i, 3'b000} +: 8];
    assign half_lane = offset_i[1] ? dout_i[31:16] : dout_i[15:0];

    always_comb begin
        data_o = dout_i;
        unique case (size_i)
            SZ_B:    data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            SZ_H:    data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: data_o = dout_i;
        endcase
    end
endmodule

// File: rtl/dpram_lsu.sv
// Load/store adapter in front of data RAM port B: checks, drives the RAM
// combinationally and returns the aligned load data one cycle later.
//
// state   | meaning
// ST_IDLE | no response outstanding
// ST_RESP | response valid, waiting for rsp_ready
module dpram_lsu
    import dpram_lsu_pkg::*;
#(
    parameter int RAM_DEPTH = 2048
) (
    input  logic          clk,
    input  logic          rst_n,
    dpram_lsu_if.slave    bus
);
    localparam int AW = clogb2(RAM_DEPTH - 1);

    state_e      state_q, state_d;
    logic        err_q, is_load_q, uns_q;
    size_e       size_q;
    logic [1:0]  off_q;

    size_e       req_size;
    logic        fire, err, size_err, range_err;
    logic [3:0]  strobe_base;
    logic [31:0] din;
    logic [31:0] ld_data;

    assign req_size = size_e'(bus.req_size);

    always_comb begin
        size_err = 1'b1;
        unique case (req_size)
            SZ_B:    size_err = 1'b0;
            SZ_H:    size_err = bus.req_addr[0];
            SZ_W:    size_err = |bus.req_addr[1:0];
            default: size_err = 1'b1;
        endcase
    end

    // RAM_DEPTH is a power of two, so any set bit above the word index is out of range.
    assign range_err = |bus.req_addr[31:AW+2];
    assign err       = size_err | range_err;

    always_comb begin
        strobe_base = 4'b1111;
        din         = bus.req_wdata;
        unique case (req_size)
            SZ_B: begin
                strobe_base = 4'b0001;
                din         = {4{bus.req_wdata[7:0]}};
            end
            SZ_H: begin
                strobe_base = 4'b0011;
                din         = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                strobe_base = 4'b1111;
                din         = bus.req_wdata;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE) | bus.rsp_ready;
    assign fire          = bus.req_valid & bus.req_ready;

    assign bus.ram_en   = fire & ~err;
    assign bus.ram_addr = bus.req_addr[AW+1:2];
    assign bus.ram_we   = bus.ram_en & bus.req_we;
    assign bus.ram_wem  = bus.ram_we ? (strobe_base << bus.req_addr[1:0]) : 4'b0000;
    assign bus.ram_din  = din;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (fire) state_d = ST_RESP;
            ST_RESP: begin
                if (fire)                state_d = ST_RESP;
                else if (bus.rsp_ready)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            is_load_q <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_B;
            off_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            if (fire) begin
                err_q     <= err;
                is_load_q <= ~bus.req_we;
                uns_q     <= bus.req_unsigned;
                size_q    <= req_size;
                off_q     <= bus.req_addr[1:0];
            end
        end
    end

    // The RAM holds ram_dout while ram_en is low, so no data copy is kept here.
    dpram_lsu_ld_align u_ld_align (
        .dout_i     (bus.ram_dout),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = bus.rsp_valid & err_q;
    assign bus.rsp_rdata = (bus.rsp_valid & is_load_q & ~err_q) ? ld_data : 32'h0;
endmodule

// File: tb/tb_dpram_lsu.sv
// Directed bench for dpram_lsu with a behavioural 1-cycle-latency RAM on port B.
module tb_dpram_lsu;
    import dpram_lsu_pkg::*;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_lsu_if #(.AW(AW)) bus ();

    dpram_lsu #(.RAM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] dout_q;
    assign bus.ram_dout = dout_q;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        dout_q = 32'h0;
    end

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wem[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end else begin
                dout_q <= mem[bus.ram_addr];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  wem;
        logic [31:0] din;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic en,
                                input logic [3:0] wem, input logic [31:0] din,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.en = en; v.wem = wem; v.din = din; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
    endtask

    vec_t vecs[17];
    logic [31:0] held;
    logic [31:0] exp_a;

    initial begin
        vecs[0]  = mk(1, 32'h10,   2'b10, 0, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(0, 32'h10,   2'b10, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 32'h13,   2'b00, 0, 32'h00000080, 1, 4'b1000, 32'h80808080, 32'h0,        0);
        vecs[3]  = mk(0, 32'h13,   2'b00, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFFF80, 0);
        vecs[4]  = mk(0, 32'h13,   2'b00, 1, 32'h0,        1, 4'b0000, 32'h0,        32'h00000080, 0);
        vecs[5]  = mk(0, 32'h12,   2'b01, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFF80AD, 0);
        vecs[6]  = mk(0, 32'h10,   2'b01, 1, 32'h0,        1, 4'b0000, 32'h0,        32'h0000BEEF, 0);
        vecs[7]  = mk(0, 32'h11,   2'b00, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hFFFFFFBE, 0);
        vecs[8]  = mk(1, 32'h16,   2'b01, 0, 32'h12345678, 1, 4'b1100, 32'h56785678, 32'h0,        0);
        vecs[9]  = mk(0, 32'h14,   2'b10, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h56780000, 0);
        vecs[10] = mk(0, 32'h11,   2'b01, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[11] = mk(0, 32'h20,   2'b11, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[12] = mk(0, 32'h2000, 2'b10, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[13] = mk(0, 32'h12,   2'b10, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
        vecs[14] = mk(1, 32'h1FFC, 2'b10, 0, 32'hA5A5A5A5, 1, 4'b1111, 32'hA5A5A5A5, 32'h0,        0);
        vecs[15] = mk(0, 32'h1FFC, 2'b10, 0, 32'h0,        1, 4'b0000, 32'h0,        32'hA5A5A5A5, 0);
        vecs[16] = mk(1, 32'h20,   2'b11, 0, 32'hFFFFFFFF, 0, 4'b0000, 32'h0,        32'h0,        1);

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("reset rsp_err",   {31'h0, bus.rsp_err},   32'h0);
        chk("reset rsp_rdata", bus.rsp_rdata,          32'h0);
        chk("reset req_ready", {31'h0, bus.req_ready}, 32'h1);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d req_ready", i), {31'h0, bus.req_ready}, 32'h1);
            chk($sformatf("v%0d ram_en", i),    {31'h0, bus.ram_en},    {31'h0, vecs[i].en});
            chk($sformatf("v%0d ram_we", i),    {31'h0, bus.ram_we},    {31'h0, vecs[i].en & vecs[i].we});
            chk($sformatf("v%0d ram_wem", i),   {28'h0, bus.ram_wem},   {28'h0, vecs[i].wem});
            if (vecs[i].en) begin
                exp_a = vecs[i].addr;
                chk($sformatf("v%0d ram_addr", i), {21'h0, bus.ram_addr}, {21'h0, exp_a[12:2]});
            end
            if (vecs[i].en && vecs[i].we)
                chk($sformatf("v%0d ram_din", i), bus.ram_din, vecs[i].din);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d rsp_valid", i), {31'h0, bus.rsp_valid}, 32'h1);
            chk($sformatf("v%0d rsp_err", i),   {31'h0, bus.rsp_err},   {31'h0, vecs[i].err});
            chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata,          vecs[i].rdata);
            chk($sformatf("v%0d ram_en idle", i), {31'h0, bus.ram_en},  32'h0);
        end

        // Stall: load held 5 cycles with a competing request waiting.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(0, 32'h10, 2'b10, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 32'h14, 2'b10, 0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d rsp_valid", c), {31'h0, bus.rsp_valid}, 32'h1);
            chk($sformatf("stall%0d req_ready", c), {31'h0, bus.req_ready}, 32'h0);
            chk($sformatf("stall%0d ram_en", c),    {31'h0, bus.ram_en},    32'h0);
            chk($sformatf("stall%0d rsp_rdata", c), bus.rsp_rdata,          32'h80ADBEEF);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall release req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("stall release ram_en",    {31'h0, bus.ram_en},    32'h1);
        chk("stall release rdata",     bus.rsp_rdata,          32'h80ADBEEF);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("after stall rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("after stall rdata",     bus.rsp_rdata,          32'h56780000);

        // Stream: store/load pairs to the same word, one fire per cycle.
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8)
                drive(k[0] ? 1'b0 : 1'b1, 32'h40 + 32'(k / 2) * 4, 2'b10, 0,
                      32'h11110000 * 32'(k / 2 + 1) + 32'(k));
            else
                bus.req_valid = 1'b0;
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("stream%0d req_ready", k), {31'h0, bus.req_ready}, 32'h1);
                chk($sformatf("stream%0d ram_en", k),    {31'h0, bus.ram_en},    32'h1);
            end
            if (k > 0) begin
                chk($sformatf("stream%0d rsp_valid", k - 1), {31'h0, bus.rsp_valid}, 32'h1);
                held = ((k - 1) % 2 == 1) ? 32'h11110000 * 32'((k - 1) / 2 + 1) + 32'(k - 2) : 32'h0;
                chk($sformatf("stream%0d rsp_rdata", k - 1), bus.rsp_rdata, held);
            end
        end

        // Reset with a response pending.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(0, 32'h10, 2'b10, 0, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("async reset rsp_rdata", bus.rsp_rdata,          32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("post-reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        drive(0, 32'h10, 2'b10, 0, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post-reset load", bus.rsp_rdata, 32'h80ADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
